decode_1to2: RTL and testbench

- 1-to-2 line decoder. It is the leaf cell that decode2to4 and wider decoder trees cascade, with each child stage's ENABLE driven from a parent OUT bit.
- Decode path is purely combinational, so a cascade adds no latency.
- A clocked side path provides a registered copy of the outputs and optional per-line select statistics for debug and coverage.

---
 rtl/decode_1to2.sv | 85 ++++++++
 tb/tb_decode_1to2.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_1to2.sv
// rtl/decode_1to2.sv - 1-to-2 line decoder with registered copy and optional select counters
// Optional feature macro: DECODE_1TO2_STATS_EN (enables CLR, CNT0/CNT1 saturating counters)
module decode_1to2 #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN,
  input  logic             ENABLE,
  output logic [1:0]       OUT,
  output logic [1:0]       OUT_Q,
  input  logic             CLR,
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1
);

  logic [1:0] out_d;
  logic [1:0] out_reg_q;

  // Decode with plain bitwise operators so unknowns on IN/ENABLE reach OUT.
  always_comb begin
    out_d    = 2'b00;
    out_d[0] = ENABLE & ~IN;
    out_d[1] = ENABLE & IN;
  end

  assign OUT = out_d;

  // Registered copy of the decode, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_reg_q <= 2'b00;
    end else begin
      out_reg_q <= out_d;
    end
  end

  assign OUT_Q = out_reg_q;

`ifdef DECODE_1TO2_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt0_d, cnt0_q;
  logic [CNT_W-1:0] cnt1_d, cnt1_q;

  // Next counts: clear wins, otherwise bump the active line and stick at max.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (CLR) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (out_d[0] && (cnt0_q != CNT_MAX)) begin
        cnt0_d = cnt0_q + CNT_ONE;
      end
      if (out_d[1] && (cnt1_q != CNT_MAX)) begin
        cnt1_d = cnt1_q + CNT_ONE;
      end
    end
  end

  // Counter state, cleared asynchronously with the rest of the side path.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign CNT0 = cnt0_q;
  assign CNT1 = cnt1_q;
`else
  // Statistics absent: counters read as zero and CLR has no effect.
  logic unused_clr;
  assign unused_clr = CLR;
  assign CNT0       = '0;
  assign CNT1       = '0;
`endif

endmodule

// File: tb/tb_decode_1to2.sv
// tb/tb_decode_1to2.sv - randomized self-checking bench for decode_1to2
`timescale 1ns/1ps
module tb_decode_1to2;

  localparam int W_BIG   = 16;
  localparam int W_SML   = 2;
  localparam int MAX_BIG = (1 << W_BIG) - 1;
  localparam int MAX_SML = (1 << W_SML) - 1;
`ifdef DECODE_1TO2_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             CLK, RESET_N, IN, ENABLE, CLR;
  logic [1:0]       out_b, oq_b, out_s, oq_s;
  logic [W_BIG-1:0] c0_b, c1_b;
  logic [W_SML-1:0] c0_s, c1_s;

  logic [1:0]       sel;
  logic             casc_en;
  logic [1:0]       p_out, p_oq, k0_out, k0_oq, k1_out, k1_oq;
  logic [15:0]      p_c0, p_c1, k0_c0, k0_c1, k1_c0, k1_c1;

  int n_vec, n_err;

  // reference model state
  logic [1:0] m_oq;
  int m_c0b, m_c1b, m_c0s, m_c1s;

  decode_1to2 #(.CNT_W(W_BIG)) dut_big (
    .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .ENABLE(ENABLE),
    .OUT(out_b), .OUT_Q(oq_b), .CLR(CLR), .CNT0(c0_b), .CNT1(c1_b));

  decode_1to2 #(.CNT_W(W_SML)) dut_sml (
    .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .ENABLE(ENABLE),
    .OUT(out_s), .OUT_Q(oq_s), .CLR(CLR), .CNT0(c0_s), .CNT1(c1_s));

  decode_1to2 u_parent (
    .CLK(CLK), .RESET_N(RESET_N), .IN(sel[1]), .ENABLE(casc_en),
    .OUT(p_out), .OUT_Q(p_oq), .CLR(1'b0), .CNT0(p_c0), .CNT1(p_c1));

  decode_1to2 u_child0 (
    .CLK(CLK), .RESET_N(RESET_N), .IN(sel[0]), .ENABLE(p_out[0]),
    .OUT(k0_out), .OUT_Q(k0_oq), .CLR(1'b0), .CNT0(k0_c0), .CNT1(k0_c1));

  decode_1to2 u_child1 (
    .CLK(CLK), .RESET_N(RESET_N), .IN(sel[0]), .ENABLE(p_out[1]),
    .OUT(k1_out), .OUT_Q(k1_oq), .CLR(1'b0), .CNT0(k1_c0), .CNT1(k1_c1));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line k of a 1-to-2 decoder is high exactly when enabled and the select equals k.
  function automatic logic [1:0] ref_out(input logic i, input logic e);
    return e ? (2'b01 << i) : 2'b00;
  endfunction

  function automatic logic [W_BIG-1:0] exp_big(input int v);
    return STATS ? W_BIG'(v) : '0;
  endfunction

  function automatic logic [W_SML-1:0] exp_sml(input int v);
    return STATS ? W_SML'(v) : '0;
  endfunction

  task automatic model_reset();
    m_oq  = 2'b00;
    m_c0b = 0; m_c1b = 0; m_c0s = 0; m_c1s = 0;
  endtask

  // Advance one clock edge and apply the spec rules to the model; returns 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    if (!RESET_N) begin
      model_reset();
    end else begin
      m_oq = ref_out(IN, ENABLE);
      if (CLR) begin
        m_c0b = 0; m_c1b = 0; m_c0s = 0; m_c1s = 0;
      end else if (ENABLE) begin
        if (IN) begin
          if (m_c1b < MAX_BIG) m_c1b++;
          if (m_c1s < MAX_SML) m_c1s++;
        end else begin
          if (m_c0b < MAX_BIG) m_c0b++;
          if (m_c0s < MAX_SML) m_c0s++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    IN = 1'b1; ENABLE = 1'b1; CLR = 1'b0;
    #1 RESET_N = 1'b0;
    model_reset();
    #1;
    n_vec++; if (out_b !== 2'b10) begin n_err++; $display("FAIL reset_out: got %b expected 10", out_b); end
    n_vec++; if (oq_b !== 2'b00) begin n_err++; $display("FAIL reset_oq: got %b expected 00", oq_b); end
    n_vec++; if (c0_b !== '0) begin n_err++; $display("FAIL reset_cnt0: got %0d expected 0", c0_b); end
    n_vec++; if (c1_b !== '0) begin n_err++; $display("FAIL reset_cnt1: got %0d expected 0", c1_b); end
    step();
    step();
    n_vec++; if (oq_b !== 2'b00) begin n_err++; $display("FAIL reset_held_oq: got %b expected 00", oq_b); end
    n_vec++; if (c1_b !== '0) begin n_err++; $display("FAIL reset_held_cnt1: got %0d expected 0", c1_b); end
    RESET_N = 1'b1;
    step();
    n_vec++; if (oq_b !== 2'b10) begin n_err++; $display("FAIL release_oq: got %b expected 10", oq_b); end
    n_vec++; if (c1_b !== exp_big(1)) begin n_err++; $display("FAIL release_cnt1: got %0d expected %0d", c1_b, exp_big(1)); end
  endtask

  task automatic test_sweep();
    logic [1:0] v;
    for (int i = 0; i < 8; i++) begin
      v = i[1:0];
      IN = v[1]; ENABLE = v[0];
      #1;
      n_vec++; if (out_b !== ref_out(v[1], v[0])) begin n_err++; $display("FAIL sweep_out[%0d]: got %b expected %b", i, out_b, ref_out(v[1], v[0])); end
      n_vec++; if (out_b[0] & out_b[1]) begin n_err++; $display("FAIL sweep_onehot[%0d]: got %b expected one-hot or zero", i, out_b); end
      step();
      n_vec++; if (oq_b !== m_oq) begin n_err++; $display("FAIL sweep_oq[%0d]: got %b expected %b", i, oq_b, m_oq); end
    end
  endtask

  task automatic test_counts();
    CLR = 1'b1; ENABLE = 1'b0; IN = 1'b0;
    step();
    CLR = 1'b0; ENABLE = 1'b1; IN = 1'b0;
    repeat (5) step();
    IN = 1'b1;
    repeat (3) step();
    ENABLE = 1'b0;
    n_vec++; if (c0_b !== exp_big(5)) begin n_err++; $display("FAIL counts_cnt0: got %0d expected %0d", c0_b, exp_big(5)); end
    n_vec++; if (c1_b !== exp_big(3)) begin n_err++; $display("FAIL counts_cnt1: got %0d expected %0d", c1_b, exp_big(3)); end
  endtask

  task automatic test_disable();
    ENABLE = 1'b0; CLR = 1'b0;
    for (int i = 0; i < 10; i++) begin
      IN = i[0];
      #1;
      n_vec++; if (out_b !== 2'b00) begin n_err++; $display("FAIL disable_out[%0d]: got %b expected 00", i, out_b); end
      step();
    end
    n_vec++; if (c0_b !== exp_big(5)) begin n_err++; $display("FAIL disable_cnt0: got %0d expected %0d", c0_b, exp_big(5)); end
    n_vec++; if (c1_b !== exp_big(3)) begin n_err++; $display("FAIL disable_cnt1: got %0d expected %0d", c1_b, exp_big(3)); end
  endtask

  task automatic test_saturate();
    CLR = 1'b1;
    step();
    CLR = 1'b0; IN = 1'b1; ENABLE = 1'b1;
    repeat (6) step();
    n_vec++; if (c1_s !== exp_sml(3)) begin n_err++; $display("FAIL sat_small_cnt1: got %0d expected %0d", c1_s, exp_sml(3)); end
    n_vec++; if (c1_b !== exp_big(6)) begin n_err++; $display("FAIL sat_big_cnt1: got %0d expected %0d", c1_b, exp_big(6)); end
    n_vec++; if (c0_s !== '0) begin n_err++; $display("FAIL sat_small_cnt0: got %0d expected 0", c0_s); end
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    n_vec++; if (c1_s !== '0) begin n_err++; $display("FAIL clr_small_cnt1: got %0d expected 0", c1_s); end
    n_vec++; if (c1_b !== '0) begin n_err++; $display("FAIL clr_big_cnt1: got %0d expected 0", c1_b); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      IN     = 1'($urandom_range(0, 1));
      ENABLE = 1'($urandom_range(0, 1));
      CLR    = ($urandom_range(0, 15) == 0);
      if (!RESET_N) begin
        RESET_N = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        RESET_N = 1'b0;
        model_reset();
      end
      #1;
      n_vec++; if (out_b !== ref_out(IN, ENABLE)) begin n_err++; $display("FAIL rnd_out[%0d]: got %b expected %b", i, out_b, ref_out(IN, ENABLE)); end
      n_vec++; if (out_s !== ref_out(IN, ENABLE)) begin n_err++; $display("FAIL rnd_out_small[%0d]: got %b expected %b", i, out_s, ref_out(IN, ENABLE)); end
      n_vec++; if (oq_b !== m_oq) begin n_err++; $display("FAIL rnd_oq[%0d]: got %b expected %b", i, oq_b, m_oq); end
      n_vec++; if (c0_b !== exp_big(m_c0b)) begin n_err++; $display("FAIL rnd_cnt0[%0d]: got %0d expected %0d", i, c0_b, exp_big(m_c0b)); end
      n_vec++; if (c1_b !== exp_big(m_c1b)) begin n_err++; $display("FAIL rnd_cnt1[%0d]: got %0d expected %0d", i, c1_b, exp_big(m_c1b)); end
      n_vec++; if (c0_s !== exp_sml(m_c0s)) begin n_err++; $display("FAIL rnd_small_cnt0[%0d]: got %0d expected %0d", i, c0_s, exp_sml(m_c0s)); end
      n_vec++; if (c1_s !== exp_sml(m_c1s)) begin n_err++; $display("FAIL rnd_small_cnt1[%0d]: got %0d expected %0d", i, c1_s, exp_sml(m_c1s)); end
      step();
    end
    RESET_N = 1'b1;
    CLR = 1'b0;
  endtask

  task automatic test_cascade();
    logic [3:0] exp4;
    casc_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel  = s[1:0];
      exp4 = 4'b0001 << s;
      #1;
      n_vec++; if ({k1_out, k0_out} !== exp4) begin n_err++; $display("FAIL cascade_sel%0d: got %b expected %b", s, {k1_out, k0_out}, exp4); end
    end
    casc_en = 1'b0;
    #1;
    n_vec++; if ({k1_out, k0_out} !== 4'b0000) begin n_err++; $display("FAIL cascade_disabled: got %b expected 0000", {k1_out, k0_out}); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    RESET_N = 1'b1; IN = 1'b0; ENABLE = 1'b0; CLR = 1'b0;
    sel = 2'b00; casc_en = 1'b0;
    model_reset();
    test_reset();
    test_sweep();
    test_counts();
    test_disable();
    test_saturate();
    test_random();
    test_cascade();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
